// File: rtl/noc_out_port_arb.sv
// noc_out_port_arb: round-robin wormhole arbiter feeding one NoC output port.
// Optional 8-bit stall watchdog is built when NOC_OUTPORT_WDOG_EN is defined.
module noc_out_port_arb #(
    parameter int NPORTS     = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORTS-1:0]            req,
    input  logic [NPORTS-1:0]            in_valid,
    input  logic [3*NPORTS-1:0]          flit_id_in,
    input  logic [DATA_WIDTH*NPORTS-1:0] data_in,
    input  logic                         dcts,
    output logic [NPORTS-1:0]            rd_en,
    output logic [DATA_WIDTH-1:0]        tx,
    output logic                         rts,
    output logic                         err
);
    localparam int PW = $clog2(NPORTS);
    localparam logic [2:0] HEADER = 3'b001;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    state_t                state_nx;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_nx;
    logic [PW-1:0]         owner;
    logic [PW-1:0]         owner_nx;
    logic [LEN_W-1:0]      cnt;
    logic [LEN_W-1:0]      cnt_nx;
    logic [DATA_WIDTH-1:0] tx_nx;
    logic                  rts_nx;

    logic [NPORTS-1:0]     elig;
    logic                  found;
    logic [PW-1:0]         pick;
    logic [LEN_W-1:0]      hdr_len;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  xfer;

`ifdef NOC_OUTPORT_WDOG_EN
    logic [7:0]            wdog;
    logic [7:0]            wdog_nx;
    logic                  err_nx;
`endif

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            elig[i] = req[i] & in_valid[i]
                    & (flit_id_in[3*i +: 3] == HEADER);
        end
    end

    // Search starts just past the last completed owner, wrapping around.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            idx = (int'(ptr) + k) % NPORTS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    assign hdr_len  = data_in[int'(pick)*DATA_WIDTH + DATA_WIDTH-4 -: LEN_W];
    assign own_data = data_in[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    assign xfer     = (state == BUSY) & in_valid[owner] & dcts;

    always_comb begin
        rd_en = '0;
        if (rst && xfer) begin
            rd_en[owner] = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        cnt_nx   = cnt;
        tx_nx    = tx;
        rts_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_nx = pick;
                    cnt_nx   = (hdr_len == '0) ? LEN_W'(1) : hdr_len;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    tx_nx  = own_data;
                    rts_nx = 1'b1;
                    cnt_nx = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_nx = IDLE;
                        ptr_nx   = owner;
                    end
                end
            end
        endcase
`ifdef NOC_OUTPORT_WDOG_EN
        wdog_nx = '0;
        err_nx  = 1'b0;
        if (state == BUSY && !xfer) begin
            wdog_nx = wdog + 8'd1;
            if (wdog_nx == 8'hFF) begin
                state_nx = IDLE;
                ptr_nx   = owner;
                err_nx   = 1'b1;
                wdog_nx  = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= PW'(NPORTS-1);
            owner <= '0;
            cnt   <= '0;
            tx    <= '0;
            rts   <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            owner <= owner_nx;
            cnt   <= cnt_nx;
            tx    <= tx_nx;
            rts   <= rts_nx;
        end
    end

`ifdef NOC_OUTPORT_WDOG_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog <= '0;
            err  <= 1'b0;
        end else begin
            wdog <= wdog_nx;
            err  <= err_nx;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/noc_out_port_arb.md
NOC_OUT_PORT_ARB -- requirements
Module: noc_out_port_arb

Interface
REQ-001 SHALL have parameter NPORTS, default 5, meaning the number of input ports competing for this output; legal range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the flit width in bits.
REQ-003 SHALL have parameter LEN_W, default 12, meaning the packet-length field width.
REQ-004 clk  input  1  sole clock; every register SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 req  input  NPORTS  bit i high means input i routes its head packet to this output (LBDR port bit).
REQ-007 in_valid  input  NPORTS  bit i high means input FIFO i is non-empty.
REQ-008 flit_id_in  input  3*NPORTS  head flit id of input i, on slice [3i+2:3i].
REQ-009 data_in  input  DATA_WIDTH*NPORTS  head flit of input i, on slice [DATA_WIDTH*i +: DATA_WIDTH].
REQ-010 dcts  input  1  downstream clear-to-send.
REQ-011 rd_en  output  NPORTS  combinational one-cycle read pulse to input FIFO i.
REQ-012 tx  output  DATA_WIDTH  registered outgoing flit.
REQ-013 rts  output  1  registered request-to-send; high for exactly the cycles in which tx carries a valid flit.
REQ-014 err  output  1  one-cycle watchdog error pulse (see Configuration).

Function
REQ-015 Flit id encoding SHALL be one-hot: header 3'b001, body 3'b010, tail 3'b100; length field SHALL be data[DATA_WIDTH-4 -: LEN_W] (bits [28:17] at defaults) and SHALL count all flits including the header.
REQ-016 FSM SHALL have exactly two states, IDLE and BUSY.
REQ-017 Eligible(i) = req[i] & in_valid[i] & (flit_id_in[i]==header).
REQ-018 In IDLE, if any input is eligible, the FSM SHALL select the first eligible input searching from (ptr+1) mod NPORTS upward with wrap, register it as owner, load cnt with the header length, and enter BUSY; no rd_en SHALL be asserted in IDLE.
REQ-019 A header length of 0 SHALL be treated as 1.
REQ-020 In BUSY, rd_en[owner] SHALL equal in_valid[owner] & dcts, and all other rd_en bits SHALL be 0.
REQ-021 On each BUSY transfer cycle, tx SHALL load data_in[owner], rts SHALL be 1 next cycle, and cnt SHALL decrement by 1; on a non-transfer cycle rts SHALL be 0 next cycle and tx SHALL hold.
REQ-022 A transfer with cnt==1 SHALL return the FSM to IDLE and set ptr to owner.
REQ-023 Timing: grant decision at cycle N, first rd_en at N+1 at the earliest, and flit on tx/rts at N+2.
REQ-024 Back-to-back packets SHALL incur exactly one IDLE arbitration cycle between the tail transfer and the next header read.
REQ-025 Requests arriving while BUSY SHALL be ignored until the FSM returns to IDLE; packets SHALL never interleave on tx.
REQ-026 Input i not requesting does not consume the pointer: ptr SHALL change only on packet completion.

Reset
REQ-027 With rst=0 at a clock edge: state to IDLE, ptr to NPORTS-1 (so input 0 has first priority), owner to 0, cnt to 0, tx to 0, rts to 0, err to 0, watchdog to 0.
REQ-028 Reset mid-packet SHALL abort the packet and assert no rd_en in the reset cycle; rd_en SHALL be 0 whenever rst=0.

Configuration
REQ-029 Macro NOC_OUTPORT_WDOG_EN: when defined, an 8-bit watchdog SHALL count BUSY cycles without a transfer, clear on any transfer, and on reaching 255 SHALL force IDLE, set ptr to owner, and pulse err high for one cycle.
REQ-030 When NOC_OUTPORT_WDOG_EN is undefined, the watchdog SHALL not be built, err SHALL be tied to 0, and BUSY SHALL be held indefinitely.

Verification
REQ-031 Reset, then req=5'b00001, header length 3 plus 2 flits, dcts=1: rd_en[0] pulses on 3 consecutive cycles and rts is high for 3 cycles with flits in order.
REQ-032 Inputs 1 and 3 both issue 1-flit headers continuously from reset: grants alternate 1,3,1,3 with one IDLE cycle between grants.
REQ-033 Length-4 packet with dcts toggling 1,0,1,0: rd_en and rts follow dcts, no flit is lost or duplicated, and the tail completes after 4 transfers.
REQ-034 Header with length field 0: exactly 1 flit is transferred and the FSM returns to IDLE.
REQ-035 rst=0 asserted during the second flit of a 5-flit packet: rts=0 and state IDLE next cycle, and ptr restores input-0 priority.
REQ-036 NOC_OUTPORT_WDOG_EN defined, BUSY with in_valid[owner]=0 for 255 cycles: err pulses once and the next eligible input is granted.
